frontend_rw_scheduler: RTL and testbench

- Sits between the frontend read and write request queues and the per-(channel, rank) execution FSMs.
- Each cycle it picks at most one request (read or write) whose target FSM is ready, and registers it as a one-cycle issue pulse.
- Policy is read-priority with a write-starvation escape: a bounded write-priority burst.
- Target FSM index is the top CHWIDTH+RKWIDTH bits of the memory address, i.e. {channel, rank}.

---
 rtl/frontend_pkg.sv | 33 +++
 rtl/frontend_rw_scheduler_timer.sv | 63 ++++++
 rtl/frontend_rw_scheduler.sv | 114 +++++++++++
 tb/tb_frontend_rw_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/frontend_pkg.sv
// -----------------------------------------------------------------------------
// frontend_pkg
// Shared types and helpers for the frontend request path.
//   sched_state_e : scheduler priority mode (read priority / write priority)
//   issue_req_t   : granted request as seen by the execution FSMs
//   fsm_index()   : {channel, rank} field extraction from a memory address.
//                   The address translation path uses the same function, so
//                   both agree on which FSM owns an address.
// -----------------------------------------------------------------------------
package frontend_pkg;

  typedef enum logic {
    RD_PRI = 1'b0,
    WR_PRI = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic        isWrite;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  index;
  } issue_req_t;

  // Returns the idxW-bit field sitting at the top of a memAddrW-bit address.
  // The address is passed zero-extended to 64 bits so one function serves
  // every address width; callers cast the result down to their index width.
  function automatic logic [7:0] fsm_index(input logic [63:0] addr,
                                           input int unsigned memAddrW,
                                           input int unsigned idxW);
    return 8'(addr >> (memAddrW - idxW)) & 8'((64'd1 << idxW) - 64'd1);
  endfunction

endpackage

// File: rtl/frontend_rw_scheduler_timer.sv
// -----------------------------------------------------------------------------
// sched_starvation_timer
// Holds the write-starvation counter and the write-burst counter.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wrPri_i        : scheduler currently in write-priority mode
//   wrReqValid_i   : a write request is waiting at the queue head
//   wrGrant_i      : the write request is granted this cycle
//   forceWrite_o   : this cycle's wait completes the starvation window;
//                    switch to write priority next cycle
//   burstDone_o    : this cycle's write grant completes the write burst
// -----------------------------------------------------------------------------
module sched_starvation_timer #(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned WRITE_BURST  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wrPri_i,
  input  logic wrReqValid_i,
  input  logic wrGrant_i,
  output logic forceWrite_o,
  output logic burstDone_o
);

  logic [7:0] starveCnt_q, starveCnt_d;
  logic [7:0] burstCnt_q, burstCnt_d;
  logic       starveInc;

  always_comb begin
    starveInc    = !wrPri_i && wrReqValid_i && !wrGrant_i;
    forceWrite_o = starveInc && (starveCnt_q == 8'(STARVE_LIMIT - 1));
    burstDone_o  = wrPri_i && wrGrant_i && ((burstCnt_q + 8'd1) == 8'(WRITE_BURST));

    // Starvation only accumulates in read priority; any write grant or the
    // switch into write priority restarts the window.
    starveCnt_d = starveCnt_q;
    if (wrPri_i || wrGrant_i || forceWrite_o) begin
      starveCnt_d = '0;
    end else if (starveInc && (starveCnt_q != 8'(STARVE_LIMIT))) begin
      starveCnt_d = starveCnt_q + 8'd1;
    end

    // Burst counts write grants, not cycles; it is zero outside write
    // priority and cleared on the cycle write priority is left.
    burstCnt_d = burstCnt_q;
    if (!wrPri_i || burstDone_o || !wrReqValid_i) begin
      burstCnt_d = '0;
    end else if (wrGrant_i) begin
      burstCnt_d = burstCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
      burstCnt_q  <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      burstCnt_q  <= burstCnt_d;
    end
  end

endmodule

// File: rtl/frontend_rw_scheduler.sv
// -----------------------------------------------------------------------------
// frontend_rw_scheduler
// Picks at most one read or write request per cycle whose target execution
// FSM is ready, and issues it as a registered one-cycle pulse. Reads have
// priority until a write has waited STARVE_LIMIT cycles; then up to
// WRITE_BURST writes are granted with priority.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   rdReqValid/Addr/Id, rdReqReady: read queue head and its accept strobe
//   wrReqValid/Addr/Id, wrReqReady: write queue head and its accept strobe
//   rankReadReady/rankWriteReady  : per-FSM one-slot credit
//   issueValid/IsWrite/Addr/Id    : registered granted request
//   issueTargetVector/Index       : target FSM, one-hot and encoded
// -----------------------------------------------------------------------------
module frontend_rw_scheduler
  import frontend_pkg::*;
#(
  parameter int unsigned AXI_ADDRWIDTH          = 32,
  parameter int unsigned MEM_ADDRWIDTH          = 32,
  parameter int unsigned AXI_IDWIDTH            = 4,
  parameter int unsigned NUM_RANKEXECUTION_UNIT = 8,
  parameter int unsigned CHWIDTH                = 1,
  parameter int unsigned RKWIDTH                = 2,
  parameter int unsigned STARVE_LIMIT           = 16,
  parameter int unsigned WRITE_BURST            = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      rdReqValid,
  input  logic [AXI_ADDRWIDTH-1:0]                  rdReqAddr,
  input  logic [AXI_IDWIDTH-1:0]                    rdReqId,
  output logic                                      rdReqReady,
  input  logic                                      wrReqValid,
  input  logic [AXI_ADDRWIDTH-1:0]                  wrReqAddr,
  input  logic [AXI_IDWIDTH-1:0]                    wrReqId,
  output logic                                      wrReqReady,
  input  logic [NUM_RANKEXECUTION_UNIT-1:0]         rankReadReady,
  input  logic [NUM_RANKEXECUTION_UNIT-1:0]         rankWriteReady,
  output logic                                      issueValid,
  output logic                                      issueIsWrite,
  output logic [AXI_ADDRWIDTH-1:0]                  issueAddr,
  output logic [AXI_IDWIDTH-1:0]                    issueId,
  output logic [NUM_RANKEXECUTION_UNIT-1:0]         issueTargetVector,
  output logic [$clog2(NUM_RANKEXECUTION_UNIT)-1:0] issueTargetIndex
);

  localparam int unsigned IW = $clog2(NUM_RANKEXECUTION_UNIT);
  localparam int unsigned FW = CHWIDTH + RKWIDTH;
  localparam logic [NUM_RANKEXECUTION_UNIT-1:0] ONE_HOT0 = NUM_RANKEXECUTION_UNIT'(1);

  sched_state_e  state_q;
  logic [IW-1:0] rdIdx, wrIdx, selIdx;
  logic          rdElig, wrElig, rdGnt, wrGnt, wrPri;
  logic          forceWrite, burstDone;

  assign rdIdx = IW'(fsm_index(64'(rdReqAddr), MEM_ADDRWIDTH, FW));
  assign wrIdx = IW'(fsm_index(64'(wrReqAddr), MEM_ADDRWIDTH, FW));

  // Grant selection: eligibility is per target FSM, so a blocked read never
  // holds back a write and vice versa. Nothing is granted while in reset.
  always_comb begin
    rdElig = rst_n && rdReqValid && rankReadReady[rdIdx];
    wrElig = rst_n && wrReqValid && rankWriteReady[wrIdx];
    wrPri  = (state_q == WR_PRI);
    if (wrPri) begin
      wrGnt = wrElig;
      rdGnt = rdElig && !wrElig;
    end else begin
      rdGnt = rdElig;
      wrGnt = wrElig && !rdElig;
    end
    selIdx = wrGnt ? wrIdx : rdIdx;
  end

  assign rdReqReady = rdGnt;
  assign wrReqReady = wrGnt;

  sched_starvation_timer #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .WRITE_BURST  (WRITE_BURST)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .wrPri_i      (wrPri),
    .wrReqValid_i (wrReqValid),
    .wrGrant_i    (wrGnt),
    .forceWrite_o (forceWrite),
    .burstDone_o  (burstDone)
  );

  // Issue register: priority mode and the granted request, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= RD_PRI;
      issueValid        <= 1'b0;
      issueIsWrite      <= 1'b0;
      issueAddr         <= '0;
      issueId           <= '0;
      issueTargetVector <= '0;
      issueTargetIndex  <= '0;
    end else begin
      case (state_q)
        RD_PRI: if (forceWrite) state_q <= WR_PRI;
        WR_PRI: if (burstDone || !wrReqValid) state_q <= RD_PRI;
      endcase
      issueValid        <= rdGnt || wrGnt;
      issueIsWrite      <= wrGnt;
      issueAddr         <= wrGnt ? wrReqAddr : (rdGnt ? rdReqAddr : '0);
      issueId           <= wrGnt ? wrReqId : (rdGnt ? rdReqId : '0);
      issueTargetIndex  <= (rdGnt || wrGnt) ? selIdx : '0;
      issueTargetVector <= (rdGnt || wrGnt) ? (ONE_HOT0 << selIdx) : '0;
    end
  end

endmodule

// File: tb/tb_frontend_rw_scheduler.sv
module tb_frontend_rw_scheduler;

  localparam int LIMIT = 16;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv = 1'b0, wv = 1'b0;
  logic [31:0] ra = '0, wa = '0;
  logic [3:0]  rid = '0, wid = '0;
  logic [7:0]  rr = '0, wrr = '0;
  logic        rdReqReady, wrReqReady;
  logic        issueValid, issueIsWrite;
  logic [31:0] issueAddr;
  logic [3:0]  issueId;
  logic [7:0]  issueTargetVector;
  logic [2:0]  issueTargetIndex;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  frontend_rw_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdReqValid        (rv),
    .rdReqAddr         (ra),
    .rdReqId           (rid),
    .rdReqReady        (rdReqReady),
    .wrReqValid        (wv),
    .wrReqAddr         (wa),
    .wrReqId           (wid),
    .wrReqReady        (wrReqReady),
    .rankReadReady     (rr),
    .rankWriteReady    (wrr),
    .issueValid        (issueValid),
    .issueIsWrite      (issueIsWrite),
    .issueAddr         (issueAddr),
    .issueId           (issueId),
    .issueTargetVector (issueTargetVector),
    .issueTargetIndex  (issueTargetIndex)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: priority mode, how long the current write has waited,
  // and how many writes the current priority episode has granted.
  bit          m_wrpri;
  int          m_wait, m_burst;
  bit          exp_v, exp_w;
  logic [31:0] exp_a;
  logic [3:0]  exp_id;
  int          exp_ix;

  always @(negedge clk) begin
    bit rdE, wrE, gr, gw;
    int ri, wi;
    if (!rst_n) begin
      chk("rst_rdReady", rdReqReady, 0);
      chk("rst_wrReady", wrReqReady, 0);
      chk("rst_issueValid", issueValid, 0);
      chk("rst_vector", issueTargetVector, 0);
      chk("rst_addr", issueAddr, 0);
      m_wrpri = 0; m_wait = 0; m_burst = 0; exp_v = 0;
    end else begin
      chk("m_issueValid", issueValid, exp_v);
      chk("m_vector", issueTargetVector, exp_v ? (64'd1 << exp_ix) : 64'd0);
      if (exp_v) begin
        chk("m_isWrite", issueIsWrite, exp_w);
        chk("m_addr", issueAddr, exp_a);
        chk("m_id", issueId, exp_id);
        chk("m_index", issueTargetIndex, exp_ix);
      end
      ri = int'(ra >> 29);
      wi = int'(wa >> 29);
      rdE = rv && rr[ri];
      wrE = wv && wrr[wi];
      if (m_wrpri) begin gw = wrE; gr = rdE && !wrE; end
      else         begin gr = rdE; gw = wrE && !rdE; end
      chk("m_rdReady", rdReqReady, gr);
      chk("m_wrReady", wrReqReady, gw);
      exp_v  = gr || gw;
      exp_w  = gw;
      exp_a  = gw ? wa : ra;
      exp_id = gw ? wid : rid;
      exp_ix = gw ? wi : ri;
      if (!m_wrpri) begin
        if (gw) m_wait = 0;
        else if (wv) begin
          m_wait++;
          if (m_wait == LIMIT) begin m_wrpri = 1; m_wait = 0; m_burst = 0; end
        end
      end else begin
        if (gw) m_burst++;
        if (m_burst == BURST || !wv) begin m_wrpri = 0; m_burst = 0; m_wait = 0; end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wg[0:59];
    bit rg[0:59];
    bit racc, wacc;
    int wcnt;

    // Reset held with valid requests present.
    rv = 1; ra = 32'h2000_0000; rid = 4'd5;
    wv = 1; wa = 32'h6000_0000; wid = 4'd9;
    rr = 8'hFF; wrr = 8'hFF;
    repeat (4) @(posedge clk);
    #1 rst_n = 1;

    // Read priority: first grant right after release goes to the read.
    @(negedge clk);
    chk("rp_rdReady", rdReqReady, 1);
    chk("rp_wrReady", wrReqReady, 0);
    @(posedge clk); #1 rr = 8'hFD;
    @(negedge clk);
    chk("rp_valid", issueValid, 1);
    chk("rp_vector", issueTargetVector, 8'b0000_0010);
    chk("rp_isWrite", issueIsWrite, 0);
    chk("rp_id", issueId, 5);
    // Bypass: read target blocked, write proceeds.
    chk("bp_rdReady", rdReqReady, 0);
    chk("bp_wrReady", wrReqReady, 1);
    @(posedge clk); #1 rv = 0; wv = 0; rr = 8'hFF;
    @(negedge clk);
    chk("bp_index", issueTargetIndex, 3);
    chk("bp_isWrite", issueIsWrite, 1);
    chk("bp_id", issueId, 9);
    @(posedge clk); #1;

    // Starvation, burst, early exit and restart of the starvation window.
    rv = 1; ra = 32'h0000_0100; rid = 0;
    wv = 1; wa = 32'h6000_0040; wid = 0;
    for (int c = 0; c < 57; c++) begin
      @(negedge clk);
      wg[c] = wrReqReady;
      rg[c] = rdReqReady;
      racc = rdReqReady; wacc = wrReqReady;
      @(posedge clk); #1;
      if (racc) begin ra = {3'($urandom), 29'($urandom)}; rid = rid + 4'd1; end
      if (wacc) wid = wid + 4'd1;
      wv = (c != 37);
    end
    wcnt = 0;
    for (int c = 0; c < 16; c++) wcnt += int'(wg[c]);
    chk("sv_no_early_write", wcnt, 0);
    chk("sv_write_at_16", wg[16], 1);
    wcnt = 0;
    for (int c = 16; c < 20; c++) wcnt += int'(wg[c]);
    chk("sv_burst_len", wcnt, 4);
    chk("sv_burst_end_wr", wg[20], 0);
    chk("sv_burst_end_rd", rg[20], 1);
    chk("sv_second_episode", wg[36] && wg[37], 1);
    chk("ee_read_passes", rg[38], 1);
    wcnt = 0;
    for (int c = 39; c < 55; c++) wcnt += int'(wg[c]);
    chk("ee_starve_cleared", wcnt, 0);
    chk("ee_write_after_16", wg[55], 1);

    // Let any write-priority episode drain, then back-to-back reads.
    wv = 0; rv = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin rv = 1; ra = {3'(i), 29'h0ABC}; rid = 4'(i); end
      else rv = 0;
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", issueValid, 1);
        chk("b2b_vector", issueTargetVector, 64'd1 << (i - 1));
        chk("b2b_id", issueId, i - 1);
      end
      if (i < 8) chk("b2b_rdReady", rdReqReady, 1);
      @(posedge clk); #1;
    end

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      racc = rdReqReady; wacc = wrReqReady;
      @(posedge clk); #1;
      if (i == 1500) rst_n = 0;
      if (i == 1502) rst_n = 1;
      if (!rv || racc) begin
        rv = ($urandom_range(0, 9) != 0); ra = $urandom; rid = 4'($urandom);
      end
      if (!wv || wacc) begin
        wv = ($urandom_range(0, 3) != 0); wa = $urandom; wid = 4'($urandom);
      end
      rr  = 8'($urandom | $urandom);
      wrr = 8'($urandom | $urandom | $urandom);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
